seq_mult_unit: RTL

//   Parametrised multi-cycle shift-add multiplier for the EX stage; serves MULT and MULTU.

---
 rtl/seq_mult_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_mult_unit.sv
// Multi-cycle shift-add multiplier serving MULT/MULTU: one multiplier bit per cycle,
// sign handled by multiplying magnitudes and negating the 2*WIDTH-bit product at the end.
module seq_mult_unit #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     a_mag, b_mag;

    // Magnitudes fit in WIDTH unsigned bits, including the most-negative operand.
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_out = state_q;

endmodule
